// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared constants for the pipeline register chain.
//   PIPE_NOP    : zero constant, cast to WIDTH where used (killed/bubbled data)
//   PERF_CNT_W  : width of the performance counters
//   MAX_DEPTH   : largest supported chain depth
//   IFID..MEMWB : stage indices of the classic 5-stage CPU
package pipe_pkg;
    localparam logic     PIPE_NOP   = 1'b0;
    localparam int       PERF_CNT_W = 32;
    localparam int       MAX_DEPTH  = 8;
    localparam int       IFID       = 0;
    localparam int       IDEX       = 1;
    localparam int       EXMEM      = 2;
    localparam int       MEMWB      = 3;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage -- one pipeline register (WIDTH data bits plus a valid bit).
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous, active-low reset
//   kill       : flush this stage (beats hold)
//   hold       : keep current contents
//   bubble     : the younger neighbour is frozen, so insert an empty slot
//   load_data  : data to capture on a normal advance
//   load_valid : valid to capture on a normal advance
//   data/valid : registered stage contents
// With ZERO_ON_KILL = 0, kill and bubble clear only the valid bit.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter bit ZERO_ON_KILL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_reg  <= WIDTH'(PIPE_NOP);
            valid_reg <= 1'b0;
        end else if (kill || (!hold && bubble)) begin
            // Flush and bubble share the same effect; hold sits between
            // them in priority, hence the !hold on the bubble term.
            valid_reg <= 1'b0;
            if (ZERO_ON_KILL) begin
                data_reg <= WIDTH'(PIPE_NOP);
            end
        end else if (!hold) begin
            data_reg  <= load_data;
            valid_reg <= load_valid;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain -- DEPTH pipeline registers with uniform stall/flush control.
// Stage 0 is the youngest (IF/ID), stage DEPTH-1 the oldest (MEM/WB).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-low reset
//   data_i, valid_i     : stage-0 input
//   hold_i, flush_i     : per-stage stall / flush requests (bit k = stage k)
//   in_ready_o          : stage 0 accepts data_i this cycle (combinational)
//   stage_data_o        : all stage registers, stage k at [k*WIDTH +: WIDTH]
//   stage_valid_o       : valid bit per stage
//   data_o, valid_o     : oldest stage
//   stall_cnt_o, bubble_cnt_o, flush_cnt_o : saturating performance counters
// Optional feature macro: PIPE_PERF_CNT_EN builds the counters; without it
// the counter ports are tied to zero. DEPTH must be 1..MAX_DEPTH.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter bit ZERO_ON_KILL = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   valid_i,
    input  logic [DEPTH-1:0]       hold_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic                   in_ready_o,
    output logic [DEPTH*WIDTH-1:0] stage_data_o,
    output logic [DEPTH-1:0]       stage_valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic [PERF_CNT_W-1:0]  stall_cnt_o,
    output logic [PERF_CNT_W-1:0]  bubble_cnt_o,
    output logic [PERF_CNT_W-1:0]  flush_cnt_o
);

    // eh[k]/ef[k]: a request at stage k or any older stage affects stage k.
    logic [DEPTH-1:0] eh;
    logic [DEPTH-1:0] ef;
    logic [WIDTH-1:0] sd [DEPTH];
    logic [DEPTH-1:0] sv;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] ld_data;
        logic             ld_valid;
        logic             bub;

        // Shifting right drops the younger requests; OR of the rest.
        assign eh[gi] = |(hold_i  >> gi);
        assign ef[gi] = |(flush_i >> gi);

        if (gi == 0) begin : g_head
            assign ld_data  = data_i;
            assign ld_valid = valid_i;
            assign bub      = 1'b0;
        end else begin : g_body
            assign ld_data  = sd[gi-1];
            assign ld_valid = sv[gi-1];
            assign bub      = eh[gi-1];
        end

        pipe_stage #(
            .WIDTH        (WIDTH),
            .ZERO_ON_KILL (ZERO_ON_KILL)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .kill       (ef[gi]),
            .hold       (eh[gi]),
            .bubble     (bub),
            .load_data  (ld_data),
            .load_valid (ld_valid),
            .data       (sd[gi]),
            .valid      (sv[gi])
        );

        assign stage_data_o[gi*WIDTH +: WIDTH] = sd[gi];
    end

    assign stage_valid_o = sv;
    assign data_o        = sd[DEPTH-1];
    assign valid_o       = sv[DEPTH-1];
    assign in_ready_o    = ~eh[0];

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_reg;
    logic [PERF_CNT_W-1:0] bubble_cnt_reg;
    logic [PERF_CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (!in_ready_o && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (!valid_o && (bubble_cnt_reg != '1)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
            end
            if ((|flush_i) && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_reg;
    assign bubble_cnt_o = bubble_cnt_reg;
    assign flush_cnt_o  = flush_cnt_reg;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain -- self-checking bench for pipe_reg_chain.
// Two instances share one stimulus stream: "a" clears data on kill/bubble,
// "b" keeps data and clears only valid. A behavioural model predicts every
// output and is compared on each falling edge; directed literal checks pin
// the model at the interesting points.
module tb_pipe_reg_chain;
    localparam int W = 32;
    localparam int D = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   data_in;
    logic           valid_in;
    logic [D-1:0]   hold;
    logic [D-1:0]   flush;

    logic           a_ready, b_ready;
    logic [D*W-1:0] a_sdata, b_sdata;
    logic [D-1:0]   a_svalid, b_svalid;
    logic [W-1:0]   a_data, b_data;
    logic           a_valid, b_valid;
    logic [31:0]    a_stall, a_bub, a_flc, b_stall, b_bub, b_flc;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .ZERO_ON_KILL(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_in), .valid_i(valid_in),
        .hold_i(hold), .flush_i(flush), .in_ready_o(a_ready),
        .stage_data_o(a_sdata), .stage_valid_o(a_svalid),
        .data_o(a_data), .valid_o(a_valid),
        .stall_cnt_o(a_stall), .bubble_cnt_o(a_bub), .flush_cnt_o(a_flc)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .ZERO_ON_KILL(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_in), .valid_i(valid_in),
        .hold_i(hold), .flush_i(flush), .in_ready_o(b_ready),
        .stage_data_o(b_sdata), .stage_valid_o(b_svalid),
        .data_o(b_data), .valid_o(b_valid),
        .stall_cnt_o(b_stall), .bubble_cnt_o(b_bub), .flush_cnt_o(b_flc)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] md [2][D];
    logic         mv [2][D];
    int unsigned  m_stall [2];
    int unsigned  m_bub   [2];
    int unsigned  m_fl    [2];

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                for (int k = 0; k < D; k++) begin
                    md[n][k] = '0;
                    mv[n][k] = 1'b0;
                end
                m_stall[n] = 0;
                m_bub[n]   = 0;
                m_fl[n]    = 0;
            end else begin
                if (hold != 0)       m_stall[n]++;
                if (!mv[n][D-1])     m_bub[n]++;
                if (flush != 0)      m_fl[n]++;
                // Oldest first so stage k-1 is still its old value when read.
                for (int k = D - 1; k >= 0; k--) begin
                    if ((flush >> k) != 0) begin
                        mv[n][k] = 1'b0;
                        if (n == 0) md[n][k] = '0;
                    end else if ((hold >> k) != 0) begin
                        // frozen
                    end else if (k > 0 && (hold >> (k - 1)) != 0) begin
                        mv[n][k] = 1'b0;
                        if (n == 0) md[n][k] = '0;
                    end else if (k == 0) begin
                        md[n][k] = data_in;
                        mv[n][k] = valid_in;
                    end else begin
                        md[n][k] = md[n][k-1];
                        mv[n][k] = mv[n][k-1];
                    end
                end
            end
        end
    end

    function automatic logic [127:0] m_sdata(input int n);
        logic [127:0] r = '0;
        for (int k = 0; k < D; k++) r[k*W +: W] = md[n][k];
        return r;
    endfunction

    function automatic logic [127:0] m_svalid(input int n);
        logic [127:0] r = '0;
        for (int k = 0; k < D; k++) r[k] = mv[n][k];
        return r;
    endfunction

    function automatic logic [127:0] m_cnt(input int unsigned x);
        return PERF ? 128'(x) : 128'(0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.stage_data",  128'(a_sdata),  m_sdata(0));
            check("a.stage_valid", 128'(a_svalid), m_svalid(0));
            check("a.data_o",      128'(a_data),   128'(md[0][D-1]));
            check("a.valid_o",     128'(a_valid),  128'(mv[0][D-1]));
            check("a.in_ready",    128'(a_ready),  128'(hold == 0));
            check("a.stall_cnt",   128'(a_stall),  m_cnt(m_stall[0]));
            check("a.bubble_cnt",  128'(a_bub),    m_cnt(m_bub[0]));
            check("a.flush_cnt",   128'(a_flc),    m_cnt(m_fl[0]));
            check("b.stage_data",  128'(b_sdata),  m_sdata(1));
            check("b.stage_valid", 128'(b_svalid), m_svalid(1));
            check("b.data_o",      128'(b_data),   128'(md[1][D-1]));
            check("b.valid_o",     128'(b_valid),  128'(mv[1][D-1]));
            check("b.in_ready",    128'(b_ready),  128'(hold == 0));
            check("b.stall_cnt",   128'(b_stall),  m_cnt(m_stall[1]));
            check("b.bubble_cnt",  128'(b_bub),    m_cnt(m_bub[1]));
            check("b.flush_cnt",   128'(b_flc),    m_cnt(m_fl[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; valid_in = 1'b1; data_in = 32'hDEADBEEF;
        hold = '0; flush = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst.valid",  128'(a_svalid), 128'(0));
        check("rst.data_o", 128'(a_data),   128'(0));
        check("rst.sdata",  128'(a_sdata),  128'(0));
        check("rst.cnt",    128'({a_stall, a_bub, a_flc}), 128'(0));
        check("rst.b_cnt",  128'({b_stall, b_bub, b_flc}), 128'(0));

        // Streaming: output appears 4 edges after capture.
        rst_n = 1'b1;
        data_in = 32'h1; cyc();
        data_in = 32'h2; cyc();
        data_in = 32'h3; cyc();
        check("stream.empty", 128'(a_valid), 128'(0));
        valid_in = 1'b0; data_in = '0;
        cyc(); check("stream.d1", 128'({a_valid, a_data}), 128'({1'b1, 32'h1}));
        cyc(); check("stream.d2", 128'({a_valid, a_data}), 128'({1'b1, 32'h2}));
        cyc(); check("stream.d3", 128'({a_valid, a_data}), 128'({1'b1, 32'h3}));
        cyc(); check("stream.end", 128'({a_valid, a_data}), 128'(0));

        // Load-use stall on stage 0.
        valid_in = 1'b1;
        data_in = 32'hB; cyc();
        data_in = 32'hA; cyc();
        check("stall.setup", 128'(a_sdata[63:0]), 128'({32'hB, 32'hA}));
        hold = 4'b0001; data_in = 32'hC; #1;
        check("stall.ready", 128'(a_ready), 128'(0));
        cyc();
        check("stall.s0_keep", 128'(a_sdata[31:0]),  128'(32'hA));
        check("stall.s1_bub",  128'({a_svalid[1], a_sdata[63:32]}), 128'(0));
        check("stall.s2",      128'(a_sdata[95:64]), 128'(32'hB));
        hold = '0; cyc();
        check("stall.resume", 128'({a_svalid[1:0], a_sdata[63:0]}), 128'({2'b11, 32'hA, 32'hC}));

        // Branch flush at stage 1 with a full pipe.
        for (int i = 0; i < 4; i++) begin
            data_in = 32'h11 + i; cyc();
        end
        flush = 4'b0010; data_in = 32'h15; cyc();
        check("flush.data",  128'(a_sdata),  {32'h12, 32'h13, 32'h0, 32'h0});
        check("flush.valid", 128'(a_svalid), 128'(4'b1100));
        flush = '0;

        // Flush on stage 1 combined with hold on stage 3.
        for (int i = 0; i < 4; i++) begin
            data_in = 32'h21 + i; cyc();
        end
        flush = 4'b0010; hold = 4'b1000; data_in = 32'h25; #1;
        check("fh.ready", 128'(a_ready), 128'(0));
        cyc();
        check("fh.a_data",  128'(a_sdata),  {32'h21, 32'h22, 32'h0, 32'h0});
        check("fh.a_valid", 128'(a_svalid), 128'(4'b1100));
        check("fh.b_data",  128'(b_sdata),  {32'h21, 32'h22, 32'h23, 32'h24});
        check("fh.b_valid", 128'(b_svalid), 128'(4'b1100));

        // Reset mid-operation overrides hold and flush.
        hold = 4'b1111; flush = 4'b0001; rst_n = 1'b0; cyc();
        check("mrst.a", 128'({a_svalid, a_sdata}), 128'(0));
        check("mrst.b", 128'({b_svalid, b_sdata}), 128'(0));
        check("mrst.cnt", 128'({b_stall, b_bub, b_flc}), 128'(0));
        hold = '0; flush = '0; rst_n = 1'b1;

        // Three stall pulses, then a flush of stage 0.
        valid_in = 1'b1;
        data_in = 32'h31; cyc();
        data_in = 32'h32; cyc();
        hold = 4'b0001; data_in = 32'h33; cyc();
        check("keep.b_s1", 128'({b_svalid[1], b_sdata[63:32]}), 128'({1'b0, 32'h31}));
        hold = '0; cyc();
        hold = 4'b0001; data_in = 32'h34; cyc();
        hold = '0; cyc();
        hold = 4'b0001; data_in = 32'h35; cyc();
        hold = '0; flush = 4'b0001; cyc();
        check("keep.b_data",  128'(b_sdata),  {32'h33, 32'h33, 32'h34, 32'h34});
        check("keep.b_valid", 128'(b_svalid), 128'(4'b1010));
        check("keep.a_s0",    128'({a_svalid[0], a_sdata[31:0]}), 128'(0));
        check("cnt.stall",    128'(b_stall), PERF ? 128'(3) : 128'(0));
        check("cnt.flush",    128'(b_flc),   PERF ? 128'(1) : 128'(0));
        check("cnt.bubble",   128'(b_bub),   PERF ? 128'(6) : 128'(0));
        flush = '0; valid_in = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised chain of DEPTH pipeline registers, WIDTH bits each, with a valid bit per stage.
- Per-stage hold (stall) and flush controls. Hold propagates upstream; flush kills the stage and all younger stages; a bubble is inserted below a held stage.
- Replaces the individual hand-instanced IF/ID, ID/EX, EX/MEM and MEM/WB registers in the pipelined CPU with one block that has a uniform stall/flush contract.

Parameters:
WIDTH, 32, data bits per stage
DEPTH, 4, number of stages; stage 0 is youngest (IF/ID), stage DEPTH-1 is oldest (MEM/WB); legal range 1..8
ZERO_ON_KILL, 1, 1: data register cleared to 0 (NOP) on flush or bubble; 0: data register retains its value and only valid is cleared

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  synchronous, active-low reset
data_i  in  WIDTH  stage-0 input data
valid_i  in  1  stage-0 input valid
hold_i  in  DEPTH  per-stage stall request; bit k = stage k
flush_i  in  DEPTH  per-stage flush request; bit k = stage k
in_ready_o  out  1  stage 0 accepts data_i this cycle; equals ~eh[0]
stage_data_o  out  DEPTH*WIDTH  all stage registers; stage k at bits [k*WIDTH +: WIDTH]
stage_valid_o  out  DEPTH  valid bit per stage
data_o  out  WIDTH  stage DEPTH-1 data
valid_o  out  1  stage DEPTH-1 valid
stall_cnt_o  out  32  performance counter (see Optional Feature)
bubble_cnt_o  out  32  performance counter
flush_cnt_o  out  32  performance counter

Behaviour:
- Derived terms, combinational:
  - eh[k] = OR of hold_i[j] for j >= k (a stall downstream freezes every younger stage).
  - ef[k] = OR of flush_i[j] for j >= k (a flush kills that stage and everything younger).
- Per stage k, at posedge, in priority order:
  1. ~rst_i: data = 0, valid = 0.
  2. ef[k]: valid = 0; data = 0 if ZERO_ON_KILL, otherwise data unchanged.
  3. eh[k]: data and valid hold.
  4. k > 0 and eh[k-1]: bubble. valid = 0; data = 0 if ZERO_ON_KILL, otherwise unchanged.
  5. Otherwise load: stage 0 loads data_i/valid_i; stage k loads data and valid from stage k-1.
- Flush beats hold on the same stage; hold on stage j > k does not protect a flushed stage k.
- Latency:
  - data_i to data_o is DEPTH cycles with no holds.
  - Each cycle with eh[0] = 1 adds one cycle; data_i is not captured in that cycle.
- Upstream contract: while in_ready_o = 0, the source keeps data_i and valid_i stable. The block does not buffer.
- Flush with hold at a higher stage. Example: flush_i[1] and hold_i[3] together clear stages 0..1 and hold stages 2..3.
- Reset mid-operation clears all stages in one cycle, regardless of hold_i and flush_i.
- All outputs are registered except in_ready_o.
- After reset: all data 0, all valid 0, in_ready_o = ~hold_i reduction, counters 0.
- DEPTH = 1: no bubble path; stage 0 follows rules 1, 2, 3 and 5.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments each cycle in_ready_o = 0.
  - bubble_cnt_o increments each cycle valid_o = 0.
  - flush_cnt_o increments each cycle |flush_i = 1.
  - All counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the three ports still exist and are tied to 0; no counter flops are built.

Decomposition:
- Package pipe_pkg holds:
  - PIPE_NOP (WIDTH-independent zero constant).
  - PERF_CNT_W = 32.
  - MAX_DEPTH = 8.
  - Stage-index localparams IFID = 0, IDEX = 1, EXMEM = 2, MEMWB = 3.
- Sub-module pipe_stage: one WIDTH register plus valid bit, with inputs kill, hold and load_data/load_valid. It implements rules 1–5 locally and is instanced DEPTH times via generate.
- eh/ef prefix-OR logic and the counters live in the top module.

Test Plan:
- Reset: rst_i = 0 for 2 cycles with valid_i = 1, data_i = 32'hDEADBEEF. Required: every stage_valid_o = 0, data_o = 0, counters 0.
- Streaming: DEPTH = 4, feed 32'h1, 32'h2, 32'h3 on consecutive cycles. Required: data_o = 1, 2, 3 with valid_o = 1 exactly 4 cycles after each input.
- Load-use stall: hold_i[0] = 1 for one cycle while stage 0 = 32'hA and stage 1 = 32'hB.
  - Required: stage 0 keeps A.
  - Required: stage 1 becomes bubble (valid 0, data 0).
  - Required: in_ready_o = 0 for that cycle.
  - Required: A reaches stage 1 one cycle later.
- Branch flush: flush_i[1] = 1 with stages 0..3 valid. Required: stages 0 and 1 invalid and zero next cycle; stages 2 and 3 advance normally.
- Flush vs hold: flush_i[1] = 1 and hold_i[3] = 1 together. Required: stages 0..1 cleared, stages 2..3 unchanged.
- ZERO_ON_KILL = 0 with PIPE_PERF_CNT_EN defined: hold_i[0] pulses 3 times, then flush_i[0].
  - Required: killed data registers keep their old value with valid 0.
  - Required: stall_cnt_o = 3 and flush_cnt_o = 1.
